// File: rtl/fp_mul_result_stage_if.sv
// rtl/fp_mul_result_stage_if.sv - multiplier-to-consumer handshake bundle for the result stage
interface fp_mul_result_stage_if;
  // Upstream side: product word and flags from the combinational multiplier
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mul_result;
  logic        mul_exception;
  logic        mul_overflow;
  logic        mul_underflow;

  // Downstream side: head entry of the buffer and its classification
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_is_zero;
  logic        out_is_inf;

  // Environment around the stage: multiplier plus consumer
  modport master (
    output in_valid, mul_result, mul_exception, mul_overflow, mul_underflow, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_is_zero, out_is_inf
  );

  // The result stage itself
  modport slave (
    input  in_valid, mul_result, mul_exception, mul_overflow, mul_underflow, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_is_zero, out_is_inf
  );
endinterface

// File: rtl/fp_mul_result_stage.sv
// rtl/fp_mul_result_stage.sv - 2-entry result FIFO with classification, sticky flags and pop counter
module fp_mul_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_mul_result_stage_if.slave bus,
  input  logic                 flag_clear,
  output logic [2:0]           sticky_flags,
  output logic [CNT_W-1:0]     result_count
);

  // Each entry holds {exception, overflow, underflow, result[31:0]}
  logic [34:0]      entry0_q;
  logic [34:0]      entry1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic [2:0]       sticky_q;
  logic [2:0]       sticky_d;
  logic [CNT_W-1:0] count_q;

  logic [2:0]       in_flags;
  logic [34:0]      head;
  logic             push;
  logic             pop;
  logic             in_ready_w;
  logic             out_valid_w;

  assign in_flags = {bus.mul_exception, bus.mul_overflow, bus.mul_underflow};

  // Ready depends only on registered occupancy and reset, never on out_ready,
  // so the upstream sees no combinational path from the consumer.
  assign in_ready_w  = rst_n & (occ_q != 2'd2);
  // Valid is masked during reset so nothing is offered in the cycle being flushed.
  assign out_valid_w = rst_n & (occ_q != 2'd0);

  assign push = bus.in_valid & in_ready_w;
  assign pop  = out_valid_w & bus.out_ready;

  assign head = rd_ptr_q ? entry1_q : entry0_q;

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_result  = head[31:0];
  assign bus.out_flags   = head[34:32];
  // Classification looks only at the stored word; the sign bit is ignored.
  assign bus.out_is_zero = (head[30:0] == 31'd0);
  assign bus.out_is_inf  = (head[30:23] == 8'hFF) && (head[22:0] == 23'd0);

  assign sticky_flags = sticky_q;
  assign result_count = count_q;

  // Occupancy moves by one on push-only or pop-only and holds on both or neither.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Clear wins over the old sticky value, but a word pushed in the same cycle still sets its flags.
  always_comb begin
    sticky_d = flag_clear ? 3'b000 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | in_flags;
    end
  end

  // Entry storage: the slot under the write pointer captures the incoming word on a push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry0_q <= 35'd0;
      entry1_q <= 35'd0;
    end else if (push) begin
      if (wr_ptr_q) begin
        entry1_q <= {in_flags, bus.mul_result};
      end else begin
        entry0_q <= {in_flags, bus.mul_result};
      end
    end
  end

  // Pointers and occupancy: single-bit pointers wrap naturally modulo 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  // Sticky status flags for the ALU control logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // Delivered-result counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
